// File: rtl/output_guard.sv
// Final output safety stage: per-channel complement/timing checks gate relay and switch enables; faults latch until fault_clr.
// Latency: two cycles from input to enables/fault (one sample stage, one FSM stage); no backpressure, every cycle is evaluated.
module output_guard #(
    parameter int NCH          = 2,
    parameter int CNT_W        = 5,
    parameter int HI_LEN       = 1,
    parameter int LO_LEN       = 15,
    parameter int TOL          = 1,
    parameter int MISMATCH_MAX = 2,
    parameter int ARM_PERIODS  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     relay_a,
    input  logic [NCH-1:0]     relay_b,
    input  logic [NCH-1:0]     pulse_a,
    input  logic [NCH-1:0]     pulse_b,
    input  logic               fault_clr,
    output logic [NCH-1:0]     relay_en,
    output logic [NCH-1:0]     switch_en,
    output logic [NCH-1:0]     fault,
    output logic [2*NCH-1:0]   fault_code,
    output logic               any_fault
);

    localparam int HI_MIN = (HI_LEN - TOL < 1) ? 1 : HI_LEN - TOL;
    localparam int LO_MIN = (LO_LEN - TOL < 1) ? 1 : LO_LEN - TOL;
    localparam logic [CNT_W-1:0] HI_MIN_C = CNT_W'(HI_MIN);
    localparam logic [CNT_W-1:0] HI_MAX_C = CNT_W'(HI_LEN + TOL);
    localparam logic [CNT_W-1:0] LO_MIN_C = CNT_W'(LO_MIN);
    localparam logic [CNT_W-1:0] LO_MAX_C = CNT_W'(LO_LEN + TOL);
    localparam logic [CNT_W-1:0] RUN_SAT  = '1;

    localparam int MM_W = $clog2(MISMATCH_MAX + 2);
    localparam logic [MM_W-1:0] MM_TRIP = MM_W'(MISMATCH_MAX + 1);
    localparam logic [MM_W-1:0] MM_SAT  = '1;

    localparam int AW = (ARM_PERIODS < 2) ? 1 : $clog2(ARM_PERIODS + 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_PERIODS - 1);

    typedef enum logic [1:0] {ST_ARMING, ST_RUN, ST_FAULT} state_t;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic            r_ra_s, r_rb_s, r_pa_s, r_pb_s, r_pa_s1;
        logic [CNT_W-1:0] r_run, w_run_nxt;
        logic [MM_W-1:0] r_rmm, r_pmm, w_rmm_nxt, w_pmm_nxt;
        state_t          r_state, w_state_nxt;
        logic [AW-1:0]   r_arm, w_arm_nxt;
        logic            r_first, w_first_nxt, r_hi_ok, w_hi_ok_nxt;
        logic            r_en, r_flt;
        logic [1:0]      r_code, w_code_nxt, w_err_code;
        logic            w_edge, w_phase_bad, w_stuck;
        logic            w_err_relay, w_err_pulse, w_err_time, w_err_any;

        always_comb begin
            w_edge    = r_pa_s ^ r_pa_s1;
            w_run_nxt = w_edge ? CNT_W'(1) : ((r_run == RUN_SAT) ? r_run : r_run + 1'b1);
            // r_pa_s1 is the level of the phase that an edge just closed
            w_phase_bad = r_pa_s1 ? ((r_run < HI_MIN_C) || (r_run > HI_MAX_C))
                                  : ((r_run < LO_MIN_C) || (r_run > LO_MAX_C));
            w_stuck    = !w_edge && (w_run_nxt > (r_pa_s ? HI_MAX_C : LO_MAX_C));
            w_err_time = w_edge ? (w_phase_bad && !r_first) : w_stuck;

            w_rmm_nxt = (r_ra_s != r_rb_s) ? '0 : ((r_rmm == MM_SAT) ? r_rmm : r_rmm + 1'b1);
            w_pmm_nxt = (r_pa_s != r_pb_s) ? '0 : ((r_pmm == MM_SAT) ? r_pmm : r_pmm + 1'b1);
            w_err_relay = (w_rmm_nxt >= MM_TRIP);
            w_err_pulse = (w_pmm_nxt >= MM_TRIP);
            w_err_any   = w_err_relay || w_err_pulse || w_err_time;
            w_err_code  = w_err_relay ? 2'd1 : (w_err_pulse ? 2'd2 : (w_err_time ? 2'd3 : 2'd0));
        end

        always_comb begin
            w_state_nxt = r_state;
            w_arm_nxt   = r_arm;
            w_first_nxt = r_first;
            w_hi_ok_nxt = r_hi_ok;
            w_code_nxt  = r_code;
            case (r_state)
                ST_ARMING: begin
                    if (w_edge) begin
                        w_first_nxt = 1'b0;
                    end
                    if (w_err_any) begin
                        w_arm_nxt   = '0;
                        w_hi_ok_nxt = 1'b0;
                    end else if (w_edge) begin
                        if (r_first) begin
                            w_hi_ok_nxt = 1'b0;
                        end else if (r_pa_s1) begin
                            w_hi_ok_nxt = 1'b1;
                        end else begin
                            // rising edge: a full verified high+low period completed
                            w_hi_ok_nxt = 1'b0;
                            if (r_hi_ok) begin
                                if (r_arm == ARM_LAST) begin
                                    w_state_nxt = ST_RUN;
                                    w_arm_nxt   = '0;
                                end else begin
                                    w_arm_nxt = r_arm + 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (w_err_any) begin
                        w_state_nxt = ST_FAULT;
                        w_code_nxt  = w_err_code;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        w_state_nxt = ST_ARMING;
                        w_code_nxt  = 2'd0;
                        w_first_nxt = 1'b1;
                        w_arm_nxt   = '0;
                        w_hi_ok_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_ARMING;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ra_s  <= 1'b0;
                r_rb_s  <= 1'b0;
                r_pa_s  <= 1'b0;
                r_pb_s  <= 1'b0;
                r_pa_s1 <= 1'b0;
                r_run   <= '0;
                r_rmm   <= '0;
                r_pmm   <= '0;
                r_state <= ST_ARMING;
                r_arm   <= '0;
                r_first <= 1'b1;
                r_hi_ok <= 1'b0;
                r_en    <= 1'b0;
                r_flt   <= 1'b0;
                r_code  <= 2'd0;
            end else begin
                r_ra_s  <= relay_a[g];
                r_rb_s  <= relay_b[g];
                r_pa_s  <= pulse_a[g];
                r_pb_s  <= pulse_b[g];
                r_pa_s1 <= r_pa_s;
                r_run   <= w_run_nxt;
                r_rmm   <= w_rmm_nxt;
                r_pmm   <= w_pmm_nxt;
                r_state <= w_state_nxt;
                r_arm   <= w_arm_nxt;
                r_first <= w_first_nxt;
                r_hi_ok <= w_hi_ok_nxt;
                r_en    <= (w_state_nxt == ST_RUN);
                r_flt   <= (w_state_nxt == ST_FAULT);
                r_code  <= w_code_nxt;
            end
        end

        assign relay_en[g]          = r_en;
        assign switch_en[g]         = r_en;
        assign fault[g]             = r_flt;
        assign fault_code[2*g +: 2] = r_code;
    end

    assign any_fault = |fault;

endmodule

// File: tb/tb_output_guard.sv
// Directed bench for output_guard: nominal 1/15 pulse trains with per-channel fault injection.
module tb_output_guard;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] relay_a, relay_b, pulse_a, pulse_b;
    logic       fault_clr;
    logic [1:0] relay_en, switch_en, fault;
    logic [3:0] fault_code;
    logic       any_fault;

    int n_chk  = 0;
    int n_fail = 0;
    int ph     = 0;
    logic [1:0] frc_hi = 2'b00, frc_lo = 2'b00, rb_eq = 2'b00, pb_eq = 2'b00;

    always #5 clk = ~clk;

    output_guard dut (
        .clk(clk), .rst(rst),
        .relay_a(relay_a), .relay_b(relay_b),
        .pulse_a(pulse_a), .pulse_b(pulse_b),
        .fault_clr(fault_clr),
        .relay_en(relay_en), .switch_en(switch_en),
        .fault(fault), .fault_code(fault_code), .any_fault(any_fault)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // drive one cycle of stimulus for phase ph, then step past the clock edge
    task automatic tick();
        for (int c = 0; c < 2; c++) begin
            logic pa;
            pa = (ph == 0);
            if (frc_hi[c]) pa = 1'b1;
            if (frc_lo[c]) pa = 1'b0;
            pulse_a[c] = pa;
            pulse_b[c] = pb_eq[c] ? pa : ~pa;
            relay_a[c] = 1'b1;
            relay_b[c] = rb_eq[c];
        end
        @(posedge clk);
        #1;
        ph = (ph + 1) % 16;
    endtask

    task automatic wait_ph(input int p);
        while (ph != p) tick();
    endtask

    initial begin
        logic [3:0] seen;
        int waited;
        rst = 1'b1;
        fault_clr = 1'b0;
        repeat (3) tick();
        check_eq("reset_outputs", {relay_en, switch_en, fault, fault_code, any_fault}, 0);

        // arming: rising edge at cycle 32 completes the 2nd verified period
        rst = 1'b0;
        ph = 0;
        for (int j = 0; j <= 33; j++) begin
            tick();
            if (j == 16 || j == 32) check_eq("arming_en_off", {relay_en, switch_en}, 0);
        end
        check_eq("run_entry", {relay_en, switch_en}, 4'hF);

        repeat (10) begin
            repeat (16) tick();
            check_eq("run_hold", {relay_en, switch_en, fault}, 6'b111100);
        end

        wait_ph(5);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        tick(); tick();
        check_eq("clr_in_run_ignored", {relay_en, switch_en, fault}, 6'b111100);

        wait_ph(4);
        rb_eq[0] = 1'b1;
        tick(); tick();
        rb_eq[0] = 1'b0;
        tick(); tick();
        check_eq("relay_mm2_tolerated", {relay_en, switch_en, fault}, 6'b111100);

        wait_ph(4);
        rb_eq[0] = 1'b1;
        tick(); tick(); tick();
        rb_eq[0] = 1'b0;
        check_eq("relay_mm3_early", fault, 2'b00);
        tick();
        check_eq("relay_mm3_fault", fault, 2'b01);
        check_eq("relay_mm3_code", fault_code, 4'b0001);
        check_eq("relay_mm3_en", {relay_en, switch_en}, 4'b1010);
        check_eq("relay_mm3_any", any_fault, 1);

        wait_ph(0);
        tick();
        frc_hi[1] = 1'b1;
        tick(); tick();
        frc_hi[1] = 1'b0;
        check_eq("stretch_early", fault[1], 0);
        tick();
        check_eq("stretch_fault", fault, 2'b11);
        check_eq("stretch_code", fault_code, 4'b1101);

        wait_ph(6);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check_eq("clr_fault", fault, 2'b00);
        check_eq("clr_code", fault_code, 0);
        check_eq("clr_any", any_fault, 0);
        seen = 4'h0;
        for (int i = 0; i < 32; i++) begin
            tick();
            seen |= {relay_en, switch_en};
        end
        check_eq("rearm_en_off", seen, 0);
        waited = 0;
        while ({relay_en, switch_en} != 4'hF && waited < 64) begin
            tick();
            waited++;
        end
        check_eq("rearm_en_on", {relay_en, switch_en}, 4'hF);

        // low phase extended on ch0: 15 natural + forced + natural = 17 low samples
        wait_ph(1);
        repeat (15) tick();
        frc_lo[0] = 1'b1;
        tick();
        frc_lo[0] = 1'b0;
        check_eq("stuck_low_16a", fault, 2'b00);
        tick();
        check_eq("stuck_low_16b", fault, 2'b00);
        tick();
        check_eq("stuck_low_fault", fault, 2'b01);
        check_eq("stuck_low_code", fault_code, 4'b0011);

        wait_ph(5);
        rb_eq[1] = 1'b1;
        pb_eq[1] = 1'b1;
        tick(); tick(); tick();
        rb_eq[1] = 1'b0;
        pb_eq[1] = 1'b0;
        tick();
        check_eq("dual_mm_fault", fault, 2'b11);
        check_eq("dual_mm_code", fault_code, 4'b0111);

        rst = 1'b1;
        tick();
        check_eq("reset_in_fault", {relay_en, switch_en, fault, fault_code, any_fault}, 0);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/output_guard.md
# output_guard

Parametrised final output safety stage for the dual-module bus comparator. For each of NCH output channels it checks a complementary relay level pair and a complementary switch pulse pair from the two comparator modules. Relay and switch enables assert only after the pulse train has been verified during an arming phase. Any relay or pulse fault drops both enables and latches a fault code until software clears it. The block sits between the comparator modules and the output-board power/relay drivers. All edge detection and counting is synchronous to `clk`.

## Interface
- NCH, 2: number of output channels.
- CNT_W, 5: run-length counter width. Must satisfy 2^CNT_W-1 > LO_LEN+TOL.
- HI_LEN, 1: nominal high-phase length of pulse_a, in clk cycles.
- LO_LEN, 15: nominal low-phase length of pulse_a, in clk cycles.
- TOL, 1: allowed ± deviation on each phase length. The lower bound clamps to 1.
- MISMATCH_MAX, 2: number of consecutive non-complementary samples tolerated.
- ARM_PERIODS, 2: number of verified periods required before enables assert.
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- relay_a  in  NCH  relay control from module 1.
- relay_b  in  NCH  relay control from module 2. Nominally ~relay_a.
- pulse_a  in  NCH  switch pulse from module 1: high HI_LEN, low LO_LEN.
- pulse_b  in  NCH  switch pulse from module 2. Nominally ~pulse_a.
- fault_clr  in  1  one-cycle request to clear latched faults on all channels.
- relay_en  out  NCH  relay power enable per channel. Registered.
- switch_en  out  NCH  switch power enable per channel. Registered.
- fault  out  NCH  latched fault flag per channel.
- fault_code  out  2*NCH  per-channel code, bits [2i+1:2i]:
  - 0: none
  - 1: relay mismatch
  - 2: pulse complement mismatch
  - 3: pulse timing violation
- any_fault  out  1  OR of fault.

## Operation
- Sampling: all four per-channel inputs are registered once into stage S. All checks use S and S delayed by one cycle (S1).
- Edge: pulse_a_S != pulse_a_S1.
- run_len:
  - Set to 1 on an edge.
  - Otherwise incremented, saturating at 2^CNT_W-1.
  - On an edge, run_len before reload is the length of the completed phase.
- Timing violation, any of:
  - On an edge, a completed high phase is outside [max(1,HI_LEN-TOL), HI_LEN+TOL].
  - On an edge, a completed low phase is outside [max(1,LO_LEN-TOL), LO_LEN+TOL].
  - Without an edge, run_len exceeds the current level's upper bound (stuck input).
- Complement counters, one each for relay and pulse:
  - Incremented while a_S == b_S, saturating.
  - Cleared when a_S != b_S.
  - A mismatch error fires when the count reaches MISMATCH_MAX+1.
- Per-channel FSM, states ARMING, RUN, FAULT:
  - ARMING:
    - Enables are 0.
    - The first edge after entry is not length-checked.
    - Each rising edge whose preceding high and low phases both passed increments arm_cnt.
    - Any timing or mismatch error clears arm_cnt. Nothing is latched.
    - When arm_cnt reaches ARM_PERIODS, go to RUN.
  - RUN:
    - relay_en and switch_en are 1.
    - Any error goes to FAULT. The code is latched with priority 1 > 2 > 3.
  - FAULT:
    - Enables are 0 and fault is 1. The code is held.
    - fault_clr goes to ARMING and clears fault and code.
    - fault_clr is ignored in ARMING and RUN.
- fault_clr and an error on the same cycle in FAULT: the clear wins and the FSM goes to ARMING. The error is evaluated under ARMING rules from then on.
- Channels are fully independent. fault_clr is shared across channels.

## Timing
- Reset:
  - All channels go to ARMING.
  - relay_en=0, switch_en=0, fault=0, fault_code=0, any_fault=0.
  - All counters are 0.
  - Sample registers are 0.
- rst asserted mid-operation overrides any state on the next edge, including FAULT. A latched fault is lost on reset.
- Latency: an input condition present before clk edge k is in S after k. FSM and outputs reflect it after edge k+1, giving 2 cycles.
- Mismatch: a level held non-complementary for MISMATCH_MAX+1 consecutive samples faults 2 cycles after the last of those samples.
- Stuck detection: fires on the first cycle run_len > upper bound.
  - Default high phase: sampled high for 3 cycles.
  - Default low phase: sampled low for 17 cycles.
- RUN entry: enables assert 2 cycles after the input rising edge that completes the ARM_PERIODS-th verified period.
- FAULT exit: enables stay 0 for at least ARM_PERIODS full periods after fault_clr.

## Test plan
- Reset, then nominal complementary pulses (1 high / 15 low), relay_a=1, relay_b=0:
  - Enables are 0 through arming.
  - Enables go to 1 two cycles after the 2nd verified rising edge.
  - Enables stay 1 for at least 10 periods with fault=0.
- In RUN, force relay_b=relay_a for 3 cycles on ch0:
  - fault[0]=1, code=1, relay_en[0]=switch_en[0]=0 two cycles after the 3rd sample.
  - ch1 is unaffected.
- In RUN, force relay_b=relay_a for only 2 cycles: no fault, enables stay 1.
- In RUN, stretch the high phase to 3 cycles on ch1: fault code=3.
- Separately, in RUN, hold pulse_a low for 17 cycles: fault code=3 at the 17th sample.
- Relay mismatch and pulse complement mismatch complete in the same cycle: code=1.
- Pulse fault, then fault_clr:
  - FAULT→ARMING, fault=0.
  - Enables come back only after 2 verified periods.
- fault_clr during RUN is ignored.
- rst asserted while in FAULT clears all outputs to 0.
